// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART definitions: state encoding, data width, bit timing
package uart_defs;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Truncating divide; the receiver uses the same function so both ends agree on bit timing.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with clear and end-of-bit pulse
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary; clear holds it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_done = !i_clear && (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with valid/ready byte input, optional even parity and stop-bit count
module uart_tx
    import uart_defs::*;
#(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 115200,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    uart_state_e r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic        r_stop_cnt, w_stop_cnt_nxt;
    logic        r_parity, w_parity_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_ready, w_ready_nxt;
    logic        w_bit_done;
    logic        w_accept;
    logic        w_baud_clear;
    logic        w_last_stop;

    assign w_accept     = tx_valid && r_ready;
    assign w_baud_clear = (r_state == ST_IDLE);
    assign w_last_stop  = (STOP_BITS == 1) || r_stop_cnt;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_baud_clear),
        .o_bit_done (w_bit_done)
    );

    // Next-state and next-output decode; the line level is computed here and registered so tx never glitches.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_ready_nxt    = r_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = ST_START;
                    w_shift_nxt    = tx_data;
                    w_parity_nxt   = ^tx_data;
                    w_bit_cnt_nxt  = '0;
                    w_stop_cnt_nxt = 1'b0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_ready_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (w_last_stop) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drives the line high immediately and abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_ready = r_ready;

endmodule
